fwd_hazard_ctrl: RTL and testbench



---
 rtl/fwd_hazard_ctrl_pkg.sv | 19 +
 rtl/fwd_hazard_ctrl_if.sv | 24 ++
 rtl/fwd_hazard_ctrl_src_cmp.sv | 18 +
 rtl/fwd_hazard_ctrl.sv | 44 ++++
 tb/tb_fwd_hazard_ctrl.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// pe_pkg: shared forwarding types, shadow-entry layout and producer-match helper
package pe_pkg;
    localparam int REG_AW = 5;
    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              is_load;
    } shadow_t;
    // A stage produces r only if it is live, writes, targets r, and r is not x0
    function automatic logic writes(input shadow_t s, input logic [REG_AW-1:0] r);
        return s.valid & s.reg_write & (s.rd == r) & (|r);
    endfunction
endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// fwd_hazard_ctrl_if: ID-stage request fields and EX-stage forwarding controls
interface fwd_hazard_ctrl_if #(parameter int REG_AW = pe_pkg::REG_AW);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_is_load;
    logic              flush;
    logic              stall;
    pe_pkg::fwd_sel_t  fwd_sel_a;
    pe_pkg::fwd_sel_t  fwd_sel_b;
    logic              ex_valid;
    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_is_load, flush,
        input  stall, fwd_sel_a, fwd_sel_b, ex_valid
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_is_load, flush,
        output stall, fwd_sel_a, fwd_sel_b, ex_valid
    );
endinterface

// File: rtl/fwd_hazard_ctrl_src_cmp.sv
// fwd_src_cmp: per-source producer match against EX and MEM shadow entries
module fwd_src_cmp
    import pe_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  logic              use_rs,
    input  shadow_t           ex,
    input  shadow_t           mem,
    output fwd_sel_t          sel,
    output logic              load_hit
);
    logic ex_hit;
    logic mem_hit;
    assign ex_hit   = use_rs & writes(ex, rs);
    assign mem_hit  = use_rs & writes(mem, rs);
    assign sel      = ex_hit ? FWD_EXMEM : mem_hit ? FWD_MEMWB : FWD_RF;
    assign load_hit = ex_hit & ex.is_load;
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX operand forwarding selects and load-use/RAW stall control
module fwd_hazard_ctrl
    import pe_pkg::*;
#(
    parameter int REG_AW = pe_pkg::REG_AW,
    parameter int FWD_EN = 1
) (
    input logic               clk,
    input logic               rst,
    fwd_hazard_ctrl_if.slave  bus
);
    shadow_t  ex_s;
    shadow_t  mem_s;
    fwd_sel_t sel_a;
    fwd_sel_t sel_b;
    logic     lh_a;
    logic     lh_b;
    logic     raw;
    fwd_src_cmp u_cmp_a (
        .rs(bus.id_rs1), .use_rs(bus.id_valid & bus.id_use_rs1),
        .ex(ex_s), .mem(mem_s), .sel(sel_a), .load_hit(lh_a)
    );
    fwd_src_cmp u_cmp_b (
        .rs(bus.id_rs2), .use_rs(bus.id_valid & bus.id_use_rs2),
        .ex(ex_s), .mem(mem_s), .sel(sel_b), .load_hit(lh_b)
    );
    assign raw       = (sel_a != FWD_RF) | (sel_b != FWD_RF);
    assign bus.stall = ~rst & ~bus.flush & (lh_a | lh_b | ((FWD_EN == 0) & raw));
    assign bus.ex_valid = ex_s.valid;
    // Advance shadow pipe; a stall injects a bubble into EX and clears the selects
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_s          <= '0;
            mem_s         <= '0;
            bus.fwd_sel_a <= FWD_RF;
            bus.fwd_sel_b <= FWD_RF;
        end else begin
            mem_s         <= ex_s;
            ex_s          <= bus.stall ? '0 : shadow_t'{bus.id_valid & ~bus.flush, bus.id_rd, bus.id_reg_write, bus.id_is_load};
            bus.fwd_sel_a <= (FWD_EN != 0 && !bus.stall && !bus.flush) ? sel_a : FWD_RF;
            bus.fwd_sel_b <= (FWD_EN != 0 && !bus.stall && !bus.flush) ? sel_b : FWD_RF;
        end
    end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed forwarding/stall sequences for FWD_EN=1 and FWD_EN=0
module tb_fwd_hazard_ctrl;
    logic clk = 0;
    logic rst = 1;
    logic rst_b = 1;
    int   checks = 0;
    int   errors = 0;
    fwd_hazard_ctrl_if a ();
    fwd_hazard_ctrl_if b ();
    fwd_hazard_ctrl #(.FWD_EN(1)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
    fwd_hazard_ctrl #(.FWD_EN(0)) dut_b (.clk(clk), .rst(rst_b), .bus(b.slave));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic issue(input bit sel_b_dut, input bit v, input int rs1, input int rs2,
                         input bit u1, input bit u2, input int rd, input bit rw, input bit ld, input bit fl);
        if (sel_b_dut) begin
            b.id_valid = v; b.id_rs1 = 5'(rs1); b.id_rs2 = 5'(rs2); b.id_use_rs1 = u1; b.id_use_rs2 = u2;
            b.id_rd = 5'(rd); b.id_reg_write = rw; b.id_is_load = ld; b.flush = fl;
        end else begin
            a.id_valid = v; a.id_rs1 = 5'(rs1); a.id_rs2 = 5'(rs2); a.id_use_rs1 = u1; a.id_use_rs2 = u2;
            a.id_rd = 5'(rd); a.id_reg_write = rw; a.id_is_load = ld; a.flush = fl;
        end
        #1;
    endtask
    task automatic drain(input bit d);
        issue(d, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
    endtask
    initial begin
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_stall", {3'b0, a.stall}, 0);
        chk("rst_ex_valid", {3'b0, a.ex_valid}, 0);
        chk("rst_sel_a", {2'b0, a.fwd_sel_a}, 0);
        chk("rst_sel_b", {2'b0, a.fwd_sel_b}, 0);
        rst = 0;
        rst_b = 0;
        // add x5,x1,x2 ; sub x6,x5,x7
        issue(0, 1, 1, 2, 1, 1, 5, 1, 0, 0);
        chk("b2b_stall0", {3'b0, a.stall}, 0);
        tick();
        issue(0, 1, 5, 7, 1, 1, 6, 1, 0, 0);
        chk("b2b_stall1", {3'b0, a.stall}, 0);
        tick();
        chk("b2b_ex_valid", {3'b0, a.ex_valid}, 1);
        chk("b2b_sel_a", {2'b0, a.fwd_sel_a}, 1);
        chk("b2b_sel_b", {2'b0, a.fwd_sel_b}, 0);
        drain(0);
        // add x5 ; nop ; or x8,x9,x5
        issue(0, 1, 1, 2, 1, 1, 5, 1, 0, 0);
        tick();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        issue(0, 1, 9, 5, 1, 1, 8, 1, 0, 0);
        chk("d2_stall", {3'b0, a.stall}, 0);
        tick();
        chk("d2_sel_a", {2'b0, a.fwd_sel_a}, 0);
        chk("d2_sel_b", {2'b0, a.fwd_sel_b}, 2);
        drain(0);
        // add x5 ; addi x5,x0,1 ; and x1,x5,x5
        issue(0, 1, 1, 2, 1, 1, 5, 1, 0, 0);
        tick();
        issue(0, 1, 0, 0, 1, 0, 5, 1, 0, 0);
        tick();
        issue(0, 1, 5, 5, 1, 1, 1, 1, 0, 0);
        tick();
        chk("dbl_sel_a", {2'b0, a.fwd_sel_a}, 1);
        chk("dbl_sel_b", {2'b0, a.fwd_sel_b}, 1);
        drain(0);
        // lw x3,0(x10) ; add x4,x3,x2
        issue(0, 1, 10, 0, 1, 0, 3, 1, 1, 0);
        tick();
        issue(0, 1, 3, 2, 1, 1, 4, 1, 0, 0);
        chk("lu_stall1", {3'b0, a.stall}, 1);
        tick();
        chk("lu_bubble_ex_valid", {3'b0, a.ex_valid}, 0);
        chk("lu_bubble_sel_a", {2'b0, a.fwd_sel_a}, 0);
        chk("lu_stall2", {3'b0, a.stall}, 0);
        tick();
        chk("lu_ex_valid", {3'b0, a.ex_valid}, 1);
        chk("lu_sel_a", {2'b0, a.fwd_sel_a}, 2);
        chk("lu_sel_b", {2'b0, a.fwd_sel_b}, 0);
        drain(0);
        // addi x0 ; use x0 twice
        issue(0, 1, 1, 0, 1, 0, 0, 1, 0, 0);
        tick();
        issue(0, 1, 0, 0, 1, 1, 6, 1, 0, 0);
        chk("x0_stall", {3'b0, a.stall}, 0);
        tick();
        chk("x0_ex_valid", {3'b0, a.ex_valid}, 1);
        chk("x0_sel_a", {2'b0, a.fwd_sel_a}, 0);
        chk("x0_sel_b", {2'b0, a.fwd_sel_b}, 0);
        drain(0);
        // lw x3 ; dependent add flushed in the hazard cycle
        issue(0, 1, 10, 0, 1, 0, 3, 1, 1, 0);
        tick();
        issue(0, 1, 3, 3, 1, 1, 4, 1, 0, 1);
        chk("fl_stall", {3'b0, a.stall}, 0);
        tick();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("fl_ex_valid", {3'b0, a.ex_valid}, 0);
        chk("fl_sel_a", {2'b0, a.fwd_sel_a}, 0);
        // FWD_EN=0: add x5 ; sub x6,x5,x7 stalls two cycles
        issue(1, 1, 1, 2, 1, 1, 5, 1, 0, 0);
        tick();
        issue(1, 1, 5, 7, 1, 1, 6, 1, 0, 0);
        chk("nf_stall1", {3'b0, b.stall}, 1);
        tick();
        chk("nf_stall2", {3'b0, b.stall}, 1);
        chk("nf_bubble1", {3'b0, b.ex_valid}, 0);
        tick();
        chk("nf_stall3", {3'b0, b.stall}, 0);
        chk("nf_bubble2", {3'b0, b.ex_valid}, 0);
        tick();
        chk("nf_ex_valid", {3'b0, b.ex_valid}, 1);
        chk("nf_sel_a", {2'b0, b.fwd_sel_a}, 0);
        chk("nf_sel_b", {2'b0, b.fwd_sel_b}, 0);
        drain(1);
        // FWD_EN=0: reset asserted during the stall
        issue(1, 1, 1, 2, 1, 1, 5, 1, 0, 0);
        tick();
        issue(1, 1, 5, 7, 1, 1, 6, 1, 0, 0);
        chk("rs_pre_stall", {3'b0, b.stall}, 1);
        rst_b = 1;
        #1;
        chk("rs_stall_in_rst", {3'b0, b.stall}, 0);
        tick();
        rst_b = 0;
        #1;
        chk("rs_ex_valid", {3'b0, b.ex_valid}, 0);
        chk("rs_sel_a", {2'b0, b.fwd_sel_a}, 0);
        chk("rs_sel_b", {2'b0, b.fwd_sel_b}, 0);
        chk("rs_post_stall", {3'b0, b.stall}, 0);
        tick();
        chk("rs_post_ex_valid", {3'b0, b.ex_valid}, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
